// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parameterised oversampling UART receiver with a one-word output
//            register, valid/ready handshake, a bit_clk whose falling edge
//            marks the mid-bit sample point, and sticky frame/overrun flags.
//            The optional parity bit and parity_err flag are compiled in only
//            when the macro UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS  = 8,   // data bits per frame, 5..9
  parameter int OVERSAMPLE = 8,   // samp_en ticks per bit period, even, 4..32
  parameter int INVERT     = 1    // 1: idle-low line, start=1, stop=0
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0    // 0: even parity, 1: odd parity
`endif
) (
  input  logic                 ref_clk,
  input  logic                 reset,
  input  logic                 samp_en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 bit_clk,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W = $clog2(DATA_BITS);

  // Tick-counter compare points: mid-bit (half period) and full bit period.
  localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1  = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  // Line levels; the logical value of a data bit is the line level XOR c_INV.
  localparam logic c_INV       = (INVERT != 0);
  localparam logic c_START_LVL = c_INV;
  localparam logic c_STOP_LVL  = ~c_INV;

`ifdef UART_RX_PARITY_EN
  localparam logic c_PAR_ODD = (PARITY_ODD != 0);
`endif

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers and wires
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0]   r_cnt;         // samp_en ticks within current phase
  logic [c_IDX_W-1:0]   r_bit_idx;     // data bits sampled so far
  logic [DATA_BITS-1:0] r_shift;       // LSB-first shift register
  logic                 r_done;        // one-cycle pulse after stop sample
  logic [DATA_BITS-1:0] r_done_word;   // word captured at the stop sample
  logic                 r_done_ferr;   // stop bit was at the wrong level
  logic                 w_half_tick;   // tick landing on the half-period point
  logic                 w_full_tick;   // tick landing on the full-period point
  logic                 w_stop_tick;   // stop bit is being sampled this tick
  logic                 w_line_bit;    // de-inverted line value

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;                     // parity mismatch of current frame
  logic r_done_perr;                   // parity mismatch of completed frame
  logic w_par_exp;                     // parity bit the data bits call for
`endif

  assign w_line_bit = in ^ c_INV;

`ifdef UART_RX_PARITY_EN
  assign w_par_exp = (^r_shift) ^ c_PAR_ODD;
`endif

  // Next-state decode: everything advances only on a samp_en tick.
  always_comb begin
    w_state_nxt = r_state;
    w_half_tick = samp_en && (r_cnt == c_HALF_M1);
    w_full_tick = samp_en && (r_cnt == c_FULL_M1);
    w_stop_tick = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (samp_en && (in == c_START_LVL)) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Mid-start re-check; a line already back at idle was a glitch.
        if (w_half_tick) begin
          w_state_nxt = (in == c_START_LVL) ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (w_full_tick && (r_bit_idx == c_LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full_tick) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Returning to IDLE on the sample tick lets a start edge on the very
        // next tick begin the following frame.
        if (w_full_tick) begin
          w_state_nxt = S_IDLE;
          w_stop_tick = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Tick counter, bit index and data shift register, gated by samp_en.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (samp_en) begin
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        S_START: begin
          // Restart the count at mid-start so later samples land mid-bit.
          r_cnt <= w_half_tick ? '0 : r_cnt + c_CNT_ONE;
        end
        S_DATA: begin
          r_cnt <= w_full_tick ? '0 : r_cnt + c_CNT_ONE;
          if (w_full_tick) begin
            r_shift   <= {w_line_bit, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + c_IDX_ONE;
          end
        end
        default: begin
          r_cnt <= w_full_tick ? '0 : r_cnt + c_CNT_ONE;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Compare the sampled parity bit against the parity of the data bits.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_par_bad <= 1'b0;
    end else if ((r_state == S_PARITY) && w_full_tick) begin
      r_par_bad <= (w_line_bit != w_par_exp);
    end
  end
`endif

  // Capture the finished frame at the stop sample; handed over next cycle.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_done_word <= '0;
      r_done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_done_perr <= 1'b0;
`endif
    end else begin
      r_done <= w_stop_tick;
      if (w_stop_tick) begin
        r_done_word <= r_shift;
        r_done_ferr <= (in != c_STOP_LVL);
`ifdef UART_RX_PARITY_EN
        r_done_perr <= r_par_bad;
`endif
      end
    end
  end

  // Output word register, valid/ready handshake and sticky error flags.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (r_done) begin
        // A new word always wins; it only counts as lost data when the old
        // word is still pending and not being accepted on this edge.
        out       <= r_done_word;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
        if (r_done_ferr) begin
          frame_err <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (r_done_perr) begin
          parity_err <= 1'b1;
        end
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // bit_clk: high for the first half of each bit, falls at the sample point.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      bit_clk <= 1'b0;
    end else if (samp_en) begin
      case (r_state)
        S_IDLE: begin
          bit_clk <= (in == c_START_LVL);
        end
        S_START: begin
          if (w_half_tick) begin
            bit_clk <= 1'b0;
          end
        end
        default: begin
          if (w_full_tick) begin
            bit_clk <= 1'b0;
          end else if (w_half_tick) begin
            bit_clk <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param. Frames are built as lists
//            of line levels, one entry per bit period, and played out one
//            samp_en tick at a time (samp_en every 8th ref_clk). A small
//            model tracks the expected word stream and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int DB       = 8;
  localparam int OS       = 8;
  localparam int HALF     = OS / 2;
  localparam int INV      = 1;
  localparam int SAMP_GAP = 8;
  localparam logic START_LVL = (INV != 0);
  localparam logic STOP_LVL  = (INV == 0);
`ifdef UART_RX_PARITY_EN
  localparam int PODD = 0;
`endif

  logic          ref_clk = 1'b0;
  logic          reset;
  logic          samp_en;
  logic          line_in;
  logic          out_ready;
  logic [DB-1:0] dout;
  logic          out_valid;
  logic          bit_clk;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Accepted words seen on the handshake, and the words the model expects.
  logic [DB-1:0] acc_q[$];
  logic [DB-1:0] exp_acc[$];
  int            acc_chk = 0;

  // Pending one-cycle-latency check after a stop sample.
  bit            lat_chk = 1'b0;
  logic [DB-1:0] lat_word;

  // Reference model state.
  bit            m_valid;
  bit            m_ferr;
  bit            m_ovr;
  bit            m_perr;

  uart_rx_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .INVERT    (INV)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .ref_clk  (ref_clk),
    .reset    (reset),
    .samp_en  (samp_en),
    .in       (line_in),
    .out      (dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bit_clk  (bit_clk),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  // Record every word taken by the consumer (valid && ready before an edge).
  always begin
    @(negedge ref_clk);
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) acc_q.push_back(dout);
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One samp_en tick: line held for SAMP_GAP cycles, strobe in the last one.
  task automatic tick_with(input logic level);
    line_in = level;
    samp_en = 1'b0;
    for (int c = 1; c < SAMP_GAP; c++) begin
      @(negedge ref_clk);
      if (c == 1 && lat_chk) begin
        chk("valid_after_load", 32'(out_valid), 32'd1);
        chk("word_after_load", 32'(dout), 32'(lat_word));
        lat_chk = 1'b0;
      end
    end
    samp_en = 1'b1;
    @(negedge ref_clk);
    samp_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_with(STOP_LVL);
  endtask

  task automatic do_reset(input logic lvl);
    reset   = 1'b1;
    samp_en = 1'b0;
    line_in = lvl;
    repeat (3) @(negedge ref_clk);
    reset   = 1'b0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
    lat_chk = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
    chk({tag, "_parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic check_acc(input string tag);
    chk({tag, "_accept_count"}, 32'(acc_q.size()), 32'(exp_acc.size()));
    for (int i = acc_chk; i < exp_acc.size() && i < acc_q.size(); i++)
      chk({tag, "_accept_word"}, 32'(acc_q[i]), 32'(exp_acc[i]));
    acc_chk = exp_acc.size();
  endtask

  // Play one frame; abort_at >= 0 stops after that many ticks (no delivery).
  task automatic send_frame(input logic [DB-1:0] w, input bit stop_ok,
                            input bit par_ok, input int abort_at);
    logic lv[$];
    int   nb;
    int   stop_mid;
    logic lvl;
    logic exp_bc;
    lv.push_back(START_LVL);
    for (int i = 0; i < DB; i++) lv.push_back(w[i] ^ START_LVL);
`ifdef UART_RX_PARITY_EN
    begin
      logic pbit;
      pbit = (^w) ^ (PODD != 0);
      if (!par_ok) pbit = ~pbit;
      lv.push_back(pbit ^ START_LVL);
    end
`endif
    lv.push_back(stop_ok ? STOP_LVL : ~STOP_LVL);
    nb       = lv.size();
    stop_mid = (nb - 1) * OS + HALF;
    for (int k = 0; k < nb * OS; k++) begin
      if (abort_at >= 0 && k >= abort_at) break;
      // After the stop sample the line goes back to idle.
      lvl = (k > stop_mid) ? STOP_LVL : lv[k / OS];
      tick_with(lvl);
      exp_bc = (k <= stop_mid) ? ((k % OS) < HALF) : 1'b0;
      chk("bit_clk", 32'(bit_clk), 32'(exp_bc));
      if (k == stop_mid) begin
        chk("valid_before_load", 32'(out_valid), 32'(m_valid));
        if (m_valid && !out_ready) m_ovr = 1'b1;
        if (!stop_ok) m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) m_perr = 1'b1;
`endif
        m_valid  = 1'b1;
        lat_chk  = 1'b1;
        lat_word = w;
        if (out_ready) begin
          exp_acc.push_back(w);
          m_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [DB-1:0] w;
    bit            s_ok;
    bit            p_ok;
    out_ready = 1'b0;
    do_reset(STOP_LVL);

    // Reset state.
    chk("reset_out", 32'(dout), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_bit_clk", 32'(bit_clk), 32'd0);
    check_flags("reset");

    // Single frame, held until accepted.
    send_frame(8'hAC, 1'b1, 1'b1, -1);
    idle(2);
    chk("ac_hold_valid", 32'(out_valid), 32'd1);
    chk("ac_hold_out", 32'(dout), 32'hAC);
    check_flags("ac");
    @(negedge ref_clk);
    out_ready = 1'b1;
    exp_acc.push_back(8'hAC);
    m_valid = 1'b0;
    @(negedge ref_clk);
    chk("ac_accept_clears", 32'(out_valid), 32'd0);
    check_acc("ac");

    // Back-to-back frames with the consumer ready.
    send_frame(8'h93, 1'b1, 1'b1, -1);
    send_frame(8'h4D, 1'b1, 1'b1, -1);
    idle(2);
    check_acc("b2b");
    check_flags("b2b");

    // Back-to-back frames with nobody consuming: second word overwrites.
    out_ready = 1'b0;
    send_frame(8'h93, 1'b1, 1'b1, -1);
    send_frame(8'h4D, 1'b1, 1'b1, -1);
    idle(2);
    chk("ovr_out", 32'(dout), 32'h4D);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    check_flags("ovr");
    @(negedge ref_clk);
    out_ready = 1'b1;
    exp_acc.push_back(8'h4D);
    m_valid = 1'b0;
    @(negedge ref_clk);
    chk("ovr_drain_valid", 32'(out_valid), 32'd0);
    idle(2);
    check_acc("ovr");
    check_flags("ovr_sticky");

    // Reset clears the sticky flags.
    do_reset(STOP_LVL);
    check_flags("flag_reset");

    // Short start pulse is rejected, then a good frame is received.
    for (int i = 0; i < 3; i++) tick_with(START_LVL);
    idle(OS);
    chk("glitch_valid", 32'(out_valid), 32'd0);
    chk("glitch_bit_clk", 32'(bit_clk), 32'd0);
    check_acc("glitch");
    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle(2);
    check_acc("after_glitch");
    check_flags("after_glitch");

    // Bad stop bit: word still delivered, frame_err raised.
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    idle(2);
    check_acc("bad_stop");
    check_flags("bad_stop");

    // Reset in the middle of a frame abandons it.
    send_frame(8'h3C, 1'b1, 1'b1, 3 * OS + 2);
    do_reset(STOP_LVL);
    idle(2 * OS);
    chk("midrst_out", 32'(dout), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_bit_clk", 32'(bit_clk), 32'd0);
    check_flags("midrst");
    check_acc("midrst");

    // Line already at start level when reset is released.
    do_reset(START_LVL);
    w = DB'($urandom);
    send_frame(w, 1'b1, 1'b1, -1);
    idle(1);
    check_acc("start_at_release");

    // Random frames with random gaps and occasional bad stop/parity.
    for (int i = 0; i < 8; i++) begin
      w    = DB'($urandom);
      s_ok = ($urandom_range(0, 3) != 0);
      p_ok = ($urandom_range(0, 3) != 0);
      send_frame(w, s_ok, p_ok, -1);
      idle($urandom_range(0, 3));
    end
    idle(2);
    check_acc("random");
    check_flags("random");

`ifdef UART_RX_PARITY_EN
    // Word 0x03 under even parity: parity bit 1 is wrong, 0 is right.
    do_reset(STOP_LVL);
    send_frame(8'h03, 1'b1, 1'b0, -1);
    idle(2);
    chk("par_bad_flag", 32'(parity_err), 32'd1);
    check_acc("par_bad");
    do_reset(STOP_LVL);
    send_frame(8'h03, 1'b1, 1'b1, -1);
    idle(2);
    chk("par_good_flag", 32'(parity_err), 32'd0);
    check_acc("par_good");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 8, meaning samp_en ticks per bit period (even, 4..32).
REQ-003 The block SHALL have parameter INVERT, default 1, meaning the line is idle-low with start=1 and stop=0; with 0 the line is idle-high with start=0 and stop=1.
REQ-004 The block SHALL have port ref_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 The block SHALL have port samp_en, input, 1 bit: oversample strobe, one ref_clk cycle wide; logic advances only when it is high.
REQ-007 The block SHALL have port in, input, 1 bit: serial line, already synchronised to ref_clk.
REQ-008 The block SHALL have port out, output, DATA_BITS bits: received word, LSB received first.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out holds an unconsumed word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out when out_valid && out_ready on a ref_clk edge.
REQ-011 The block SHALL have port bit_clk, output, 1 bit: high during the first half of each bit period and low during the second half, so its falling edge is the mid-bit sample point.
REQ-012 The block SHALL have port frame_err, output, 1 bit: sticky; set when a stop bit is bad.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky; set when a word is lost.
REQ-014 The block SHALL have port parity_err, output, 1 bit: sticky; present only when the parity feature is compiled in.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; the PARITY state exists only when the parity feature is compiled in.
REQ-016 In IDLE, a samp_en tick with in at the start level SHALL move the FSM to START and clear the tick counter.
REQ-017 In START, after OVERSAMPLE/2 ticks the line SHALL be re-sampled: at the start level go to DATA; otherwise return to IDLE as a glitch, with no output or flag.
REQ-018 DATA SHALL sample in once every OVERSAMPLE ticks after the mid-start point, shifting LSB-first, with DATA_BITS samples total.
REQ-019 STOP SHALL sample one bit period after the last data or parity bit; a bad stop level sets frame_err and the word is still delivered.
REQ-020 The FSM SHALL return to IDLE on the stop sample tick, so back-to-back frames are accepted with a start edge on the next tick.
REQ-021 On the ref_clk cycle after the stop sample, out SHALL load the word and out_valid SHALL go high; latency is 1 ref_clk cycle from the stop sample.
REQ-022 out SHALL be held stable while out_valid is high; out_valid SHALL clear on the cycle after the accept.
REQ-023 If a word completes while out_valid=1 and there is no accept on the same edge, overrun SHALL be set and the new word SHALL replace out.
REQ-024 Completion and accept on the same edge SHALL load the new word with out_valid staying high and no overrun.
REQ-025 Sticky flags SHALL clear only on reset.
REQ-026 When samp_en is low, the FSM and counters SHALL hold state.

Reset
REQ-027 On a reset edge: FSM=IDLE, counters=0, out=0, out_valid=0, bit_clk=0, frame_err=0, overrun=0, parity_err=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame, produce no output, and raise no flag.
REQ-029 After reset is released, an in line already at the start level SHALL be treated as a start edge on the first samp_en tick.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, the block SHALL provide parameter PARITY_ODD (default 0), the PARITY state, and the parity_err port.
REQ-031 With UART_RX_PARITY_EN defined, one parity bit SHALL be sampled after the data bits; parity is computed on the logical (de-inverted) bits, and a mismatch sets parity_err while the word is still delivered.
REQ-032 Without UART_RX_PARITY_EN, there SHALL be no parity bit and no parity_err port, and the frame is start + DATA_BITS + stop.

Verification
REQ-033 Scenario, defaults, samp_en every 8th cycle: frame 0xAC (line bits inverted, idle 0) -> out=0xAC, out_valid 1 cycle after the stop sample, no flags.
REQ-034 Scenario: frames 0x93 then 0x4D back-to-back with out_ready=1 -> two accepts in order, overrun=0.
REQ-035 Scenario: 0x93 then 0x4D with out_ready=0 -> out=0x4D, overrun=1.
REQ-036 Scenario: start pulse 3 samp_en ticks long -> stays IDLE, out_valid=0; then valid frame 0x55 -> out=0x55.
REQ-037 Scenario: frame 0xFF with stop at the wrong level -> out=0xFF, frame_err=1; reset mid-frame on the next frame -> all outputs 0, no out_valid.
REQ-038 Scenario, UART_RX_PARITY_EN defined with PARITY_ODD=0: 0x03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
